screen_reader: RTL and testbench



---
 rtl/screen_reader_pkg.sv | 23 ++
 rtl/screen_reader_pixel_shifter.sv | 53 +++++
 rtl/screen_reader.sv | 175 +++++++++++++++++
 tb/tb_screen_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_reader_pkg
//  Description : Shared constants and FSM state encoding for the Hack screen
//                scanner (screen RAM geometry, word width, state codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package screen_reader_pkg;

    localparam int SCREEN_BASE  = 16384;
    localparam int SCREEN_WORDS = 8192;
    localparam int WORD_WIDTH   = 16;
    localparam int ADDR_W       = $clog2(SCREEN_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/screen_reader_pixel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : screen_reader_pixel_shifter
//  Description : W-bit right-shifting pixel register with a bit counter.
//                Load has priority over shift; the counter clears on load and
//                advances on every shift. o_last flags the final bit position.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load, i_data  - parallel load of a new word
//                i_shift         - shift right by one, advance counter
//                o_bit0          - current output bit (LSB)
//                o_word          - whole register (used for word hand-over)
//                o_last          - counter is at bit W-1
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_reader_pixel_shifter
    import screen_reader_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_bit0,
    output logic [W-1:0] o_word,
    output logic         o_last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {1'b0, r_sr[W-1:1]};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bit0 = r_sr[0];
    assign o_word = r_sr;
    assign o_last = (r_cnt == CW'(W-1));

endmodule
`default_nettype wire

// File: rtl/screen_reader.sv
`default_nettype none
// ============================================================================
//  Module      : screen_reader
//  Description : Walks the screen RAM word by word and serialises each word
//                into a pixel stream (LSB = leftmost pixel) with a
//                valid/ready handshake. Marks row and frame ends.
//  Config      : SCREEN_READER_PREFETCH_EN - adds a holding register that
//                fetches the next word during SHIFT, removing the per-word
//                FETCH/LOAD bubble.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                start                 - frame request (sampled in IDLE)
//                addr, rd, data        - screen RAM read port (1-cycle latency)
//                pixel, pixel_valid,
//                pixel_ready           - pixel stream handshake
//                line_end, frame_end   - qualify last pixel of row / frame
//                busy                  - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_reader
    import screen_reader_pkg::*;
#(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 256,
    parameter int WORD   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    input  logic [WORD-1:0]   data,
    output logic              pixel,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy
);

    localparam int                WORDS_PER_ROW = WIDTH / WORD;
    localparam logic [ADDR_W-1:0] LAST_WORD     = ADDR_W'(WORDS_PER_ROW * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(WORDS_PER_ROW - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;   // word index within the frame
    logic [ADDR_W-1:0] r_col;   // word column within the current row

    logic            w_xfer;
    logic            w_last_bit;
    logic            w_bit0;
    logic            w_word_done;
    logic            w_last_word;
    logic            w_load;
    logic [WORD-1:0] w_load_data;
    logic [WORD-1:0] w_sr_word_unused;

    assign w_xfer      = (r_state == ST_SHIFT) & pixel_ready;
    assign w_word_done = w_xfer & w_last_bit;
    assign w_last_word = (r_idx == LAST_WORD);

`ifdef SCREEN_READER_PREFETCH_EN
    logic            r_hold_full;
    logic            r_pend;      // read issued last cycle, data arrives now
    logic            w_pf_rd;
    logic [WORD-1:0] w_hold_word;
    logic            w_hold_bit0_unused;
    logic            w_hold_last_unused;

    // One read in flight at most; never prefetch in the cycle the current
    // word retires, so the FSM's fallback decision sees settled flags.
    assign w_pf_rd = (r_state == ST_SHIFT) & ~r_hold_full & ~r_pend
                   & ~w_last_word & ~w_word_done;

    // LOAD takes the holding register if it filled while waiting, else the
    // RAM data that is valid in this cycle.
    assign w_load      = (r_state == ST_LOAD)
                       | (w_word_done & ~w_last_word & r_hold_full);
    assign w_load_data = r_hold_full ? w_hold_word : data;

    assign rd   = (r_state == ST_FETCH) | w_pf_rd;
    assign addr = w_pf_rd ? (r_idx + ADDR_W'(1)) : r_idx;

    screen_reader_pixel_shifter #(.W(WORD)) u_hold (
        .clk     (clk),
        .rst     (reset),
        .i_load  (r_pend),
        .i_shift (1'b0),
        .i_data  (data),
        .o_bit0  (w_hold_bit0_unused),
        .o_word  (w_hold_word),
        .o_last  (w_hold_last_unused)
    );
`else
    assign w_load      = (r_state == ST_LOAD);
    assign w_load_data = data;
    assign rd          = (r_state == ST_FETCH);
    assign addr        = r_idx;
`endif

    screen_reader_pixel_shifter #(.W(WORD)) u_shift (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_shift (w_xfer),
        .i_data  (w_load_data),
        .o_bit0  (w_bit0),
        .o_word  (w_sr_word_unused),
        .o_last  (w_last_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_col   <= '0;
`ifdef SCREEN_READER_PREFETCH_EN
            r_pend      <= 1'b0;
            r_hold_full <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_col   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_LOAD;
                ST_LOAD:  r_state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (w_word_done) begin
                        if (w_last_word) begin
                            r_idx   <= '0;
                            r_col   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                            r_col <= (r_col == LAST_COL) ? '0 : r_col + ADDR_W'(1);
`ifdef SCREEN_READER_PREFETCH_EN
                            // Next word ready: continue without a bubble.
                            // Read in flight: it lands in the holding
                            // register now, LOAD picks it up next cycle.
                            if (r_hold_full)
                                r_state <= ST_SHIFT;
                            else if (r_pend)
                                r_state <= ST_LOAD;
                            else
                                r_state <= ST_FETCH;
`else
                            r_state <= ST_FETCH;
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef SCREEN_READER_PREFETCH_EN
            r_pend <= w_pf_rd;
            if (r_pend)
                r_hold_full <= 1'b1;
            else if (w_load && r_hold_full)
                r_hold_full <= 1'b0;
`endif
        end
    end

    assign pixel_valid = (r_state == ST_SHIFT);
    assign pixel       = pixel_valid & w_bit0;
    assign line_end    = pixel_valid & w_last_bit & (r_col == LAST_COL);
    assign frame_end   = line_end & w_last_word;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_screen_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_screen_reader
//  Description : Self-checking bench for screen_reader on a 32x2 screen
//                (4 words, 64 pixels). A frame-level model predicts every
//                pixel and flag from RAM contents; a RAM model answers reads
//                one cycle later with garbage on idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_reader;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 2;
    localparam int WORD   = 16;
    localparam int NW     = WIDTH / 16 * HEIGHT;
    localparam int NPIX   = NW * 16;
`ifdef SCREEN_READER_PREFETCH_EN
    localparam int EXP_BUB     = 0;
    localparam int EXP_END_CYC = 66;
`else
    localparam int EXP_BUB     = 2 * (NW - 1);
    localparam int EXP_END_CYC = 72;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] addr;
    logic        rd;
    logic [15:0] data;
    logic        pixel;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        line_end;
    logic        frame_end;
    logic        busy;

    screen_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WORD(WORD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr        (addr),
        .rd          (rd),
        .data        (data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- RAM model: data valid the cycle after rd ----------
    logic [15:0] mem [0:NW-1];
    logic        ram_req;
    logic [12:0] ram_a;

    always @(negedge clk) begin
        ram_req = rd;
        ram_a   = addr;
    end

    always @(posedge clk) begin
        #1;
        if (ram_req && int'(ram_a) < NW) data = mem[int'(ram_a)];
        else                              data = 16'($urandom);
    end

    // ---------------- sink: 0 = always ready, 1 = random, 2 = stalled ---
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       pixel_ready = 1'b1;
            1:       pixel_ready = ($urandom_range(0, 3) != 0);
            default: pixel_ready = 1'b0;
        endcase
    end

    // ---------------- frame-level reference model -----------------------
    bit m_en = 1'b0;
    bit m_active = 1'b0;
    bit m_was;
    bit m_stall = 1'b0;
    int m_idx = 0, m_cyc = 0, m_rdaddr = 0, m_first_cyc = -1;
    int m_bub = 0, m_ones = 0, m_end_cyc = 0;

    function automatic logic exp_pix(input int i);
        logic [15:0] w;
        w = mem[i / 16];
        return w[i % 16];
    endfunction

    always @(negedge clk) begin
        if (m_en) begin
            m_was = m_active;
            chk("busy", busy, m_was);
            if (!m_was) begin
                chk("idle_outputs", {rd, pixel_valid, pixel, line_end, frame_end}, 5'b0);
                chk("idle_addr", addr, 0);
                m_stall = 1'b0;
            end else begin
                m_cyc++;
                if (rd) begin
                    if (m_rdaddr == 0) chk("first_rd_cycle", m_cyc, 1);
                    chk("rd_addr", addr, m_rdaddr);
                    m_rdaddr++;
                end
                if (m_stall) chk("valid_held", pixel_valid, 1'b1);
                if (pixel_valid) begin
                    if (m_first_cyc < 0) begin
                        m_first_cyc = m_cyc;
                        chk("first_pixel_cycle", m_cyc, 3);
                    end
                    chk("pixel", pixel, exp_pix(m_idx));
                    chk("line_end", line_end, (m_idx % WIDTH) == WIDTH - 1);
                    chk("frame_end", frame_end, m_idx == NPIX - 1);
                    m_stall = !pixel_ready;
                    if (pixel_ready) begin
                        if (pixel) m_ones++;
                        m_idx++;
                        if (m_idx == NPIX) begin
                            chk("bubbles", m_bub, EXP_BUB);
                            chk("read_count", m_rdaddr, NW);
                            m_end_cyc = m_cyc;
                            m_active  = 1'b0;
                        end
                    end
                end else begin
                    m_stall = 1'b0;
                    if (m_first_cyc >= 0) m_bub++;
                end
            end
            if (!m_was && start) begin
                m_active = 1'b1;  m_idx = 0;  m_cyc = 0;  m_rdaddr = 0;
                m_first_cyc = -1; m_bub = 0;  m_ones = 0;
            end
            if (reset) begin
                m_active = 1'b0;
                m_stall  = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic rand_mem();
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Runs one frame. b2b starts in the cycle right after the previous
    // frame_end; poke drives stray start pulses while busy; sa0/sa1 are
    // pixel indices where the sink stalls for 5 cycles (-1 = none).
    task automatic run_frame(input bit b2b, input bit poke, input int sa0, input int sa1);
        int n, stall_left, saved;
        bit d0, d1;
        n = 0; stall_left = 0; saved = rmode; d0 = 1'b0; d1 = 1'b0;
        if (!b2b) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (m_active && n < 400) begin
            @(posedge clk);
            n++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) rmode = saved;
            end else if (!d0 && m_idx == sa0) begin
                d0 = 1'b1; saved = rmode; rmode = 2; stall_left = 5;
            end else if (!d1 && m_idx == sa1) begin
                d1 = 1'b1; saved = rmode; rmode = 2; stall_left = 5;
            end
            #1 start = poke && m_active && ($urandom_range(0, 9) == 0);
        end
        start = 1'b0;
        if (stall_left > 0) rmode = saved;
        chk("frame_timeout", m_active, 1'b0);
        if (m_active) do_reset();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        rand_mem();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_en = 1'b1;
        repeat (4) @(posedge clk);

        // Single black pixel at the top-left, full-rate sink.
        mem = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        run_frame(1'b0, 1'b0, -1, -1);
        chk("A_end_cycle", m_end_cyc, EXP_END_CYC);
        chk("A_ones", m_ones, 1);

        // Backpressure mid-word and on the row-end pixel.
        mem = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
        run_frame(1'b0, 1'b0, 10, 31);
        chk("B_ones", m_ones, 2);

        // Back-to-back start, stray starts while busy must be ignored.
        rand_mem();
        run_frame(1'b1, 1'b1, -1, -1);

        // Reset while pixel 7 is on the stream, then rescan.
        rand_mem();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (m_idx < 7 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("rst_reached_pixel7", m_idx >= 7, 1'b1);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", pixel_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", addr, 0);
        run_frame(1'b0, 1'b0, -1, -1);

        // Random contents, random sink, random stray starts.
        rmode = 1;
        for (int f = 0; f < 6; f++) begin
            rand_mem();
            run_frame(f[0], 1'b1, -1, (f == 2) ? 20 : -1);
        end
        rmode = 0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
